// File: rtl/dma_firewall.sv
// DMA firewall: checks each DMA gateway request against an access window and
// a write-protected sub-region, forwarding legal accesses to the backing memory.
//
// state  | meaning
// IDLE   | waiting for s_req; request checks evaluated here
// ACCESS | single-cycle memory strobe
// WAIT   | read latency countdown, mem_rdata captured on the last cycle
// RESP   | s_done pulse (with s_fault for rejected requests)
module dma_firewall #(
  parameter logic [31:0] WIN_BASE = 32'h2000_0000,
  parameter logic [31:0] WIN_SIZE = 32'h0000_1000,
  parameter logic [31:0] RO_BASE  = 32'h2000_0000,
  parameter logic [31:0] RO_SIZE  = 32'h0000_0100,
  parameter int          MEM_LAT  = 2,
  parameter int          AW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [3:0]    s_be,
  input  logic [31:0]   s_addr,
  input  logic [31:0]   s_wdata,
  output logic [31:0]   s_rdata,
  output logic          s_done,
  output logic          s_fault,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          fault_clr,
  output logic [15:0]   fault_cnt,
  output logic [31:0]   fault_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // 33-bit bounds so base+size can never wrap past 4 GiB
  localparam logic [32:0] WIN_LO   = {1'b0, WIN_BASE};
  localparam logic [32:0] WIN_HI   = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
  localparam logic [32:0] RO_LO    = {1'b0, RO_BASE};
  localparam logic [32:0] RO_HI    = {1'b0, RO_BASE} + {1'b0, RO_SIZE};
  localparam logic [1:0]  LAT_INIT = 2'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic [1:0]      lat_q, lat_d;
  logic            we_q, we_d;
  logic [31:0]     s_rdata_q, s_rdata_d;
  logic            s_done_q, s_done_d;
  logic            s_fault_q, s_fault_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     fault_cnt_q, fault_cnt_d;
  logic [31:0]     fault_addr_q, fault_addr_d;

  logic [32:0]     addr33;
  logic [31:0]     offset;
  logic            in_win, in_ro, chk_fail;

  assign addr33   = {1'b0, s_addr};
  assign offset   = s_addr - WIN_BASE;
  assign in_win   = (addr33 >= WIN_LO) && (addr33 < WIN_HI);
  assign in_ro    = (addr33 >= RO_LO) && (addr33 < RO_HI);
  assign chk_fail = (s_addr[1:0] != 2'b00) || (s_be == 4'h0) || !in_win || (s_we && in_ro);

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    we_d         = we_q;
    s_rdata_d    = s_rdata_q;
    s_done_d     = 1'b0;
    s_fault_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fault_cnt_d  = fault_clr ? 16'h0000 : fault_cnt_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      IDLE: begin
        if (s_req) begin
          we_d = s_we;
          if (chk_fail) begin
            state_d      = RESP;
            s_done_d     = 1'b1;
            s_fault_d    = 1'b1;
            s_rdata_d    = 32'h0;
            fault_addr_d = s_addr;
            if (!fault_clr && (fault_cnt_q != 16'hFFFF)) begin
              fault_cnt_d = fault_cnt_q + 16'd1;
            end
          end else begin
            state_d     = ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = s_we;
            mem_be_d    = s_be;
            mem_addr_d  = AW'(offset >> 2);
            mem_wdata_d = s_wdata;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d   = RESP;
          s_done_d  = 1'b1;
          s_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          state_d   = RESP;
          s_done_d  = 1'b1;
          s_rdata_d = mem_rdata;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_q        <= 2'd0;
      we_q         <= 1'b0;
      s_rdata_q    <= 32'h0;
      s_done_q     <= 1'b0;
      s_fault_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      fault_cnt_q  <= 16'h0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      we_q         <= we_d;
      s_rdata_q    <= s_rdata_d;
      s_done_q     <= s_done_d;
      s_fault_q    <= s_fault_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fault_cnt_q  <= fault_cnt_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign s_rdata    = s_rdata_q;
  assign s_done     = s_done_q;
  assign s_fault    = s_fault_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign fault_cnt  = fault_cnt_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dma_firewall.sv
// Directed bench for dma_firewall: latency, forwarding, fault rules, counter
// saturation/clear and reset abandonment, against hand-computed values.
module tb_dma_firewall;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_req = 1'b0;
  logic          s_we = 1'b0;
  logic [3:0]    s_be = 4'h0;
  logic [31:0]   s_addr = 32'h0;
  logic [31:0]   s_wdata = 32'h0;
  logic [31:0]   s_rdata;
  logic          s_done, s_fault;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          fault_clr = 1'b0;
  logic [15:0]   fault_cnt;
  logic [31:0]   fault_addr;

  int n_chk = 0;
  int n_err = 0;

  dma_firewall dut (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_we(s_we), .s_be(s_be),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done),
    .s_fault(s_fault), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fault_clr(fault_clr), .fault_cnt(fault_cnt), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // two-cycle read memory model: data is valid exactly MEM_LAT cycles after the strobe
  logic [31:0] rd_val = 32'h0;
  logic        v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    v1 <= mem_en & ~mem_we;
    v2 <= v1;
  end
  assign mem_rdata = v2 ? rd_val : 32'h0BAD_0BAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_fault,
                         input logic [31:0] exp_rdata, input logic [AW-1:0] exp_maddr,
                         input bit drop, input bit clr);
    int done_cyc, en_cnt, en_cyc;
    logic [AW-1:0] ma;
    logic mwe, flt;
    logic [3:0] mbe;
    logic [31:0] mwd, rd;
    done_cyc = -1; en_cnt = 0; en_cyc = -1;
    ma = '0; mwe = 1'b0; mbe = 4'h0; mwd = 32'h0; flt = 1'b0; rd = 32'h0;
    s_req = 1'b1; s_we = we; s_be = be; s_addr = addr; s_wdata = wdata; fault_clr = clr;
    for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
      @(negedge clk);
      fault_clr = 1'b0;
      if (drop) s_req = 1'b0;
      if (mem_en) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc = c; ma = mem_addr; mwe = mem_we; mbe = mem_be; mwd = mem_wdata;
        end
      end
      if (s_done) begin
        done_cyc = c; flt = s_fault; rd = s_rdata; s_req = 1'b0;
      end
    end
    chk({tag, ".done_cycle"}, done_cyc, exp_lat);
    chk({tag, ".fault"}, {31'h0, flt}, {31'h0, exp_fault});
    chk({tag, ".rdata"}, rd, exp_rdata);
    if (exp_fault) begin
      chk({tag, ".mem_en_count"}, en_cnt, 0);
    end else begin
      chk({tag, ".mem_en_count"}, en_cnt, 1);
      chk({tag, ".mem_en_cycle"}, en_cyc, 1);
      chk({tag, ".mem_we"}, {31'h0, mwe}, {31'h0, we});
      chk({tag, ".mem_be"}, {28'h0, mbe}, {28'h0, be});
      chk({tag, ".mem_addr"}, {22'h0, ma}, {22'h0, exp_maddr});
      if (we) chk({tag, ".mem_wdata"}, mwd, wdata);
    end
    @(negedge clk);
    chk({tag, ".done_pulse_end"}, {31'h0, s_done}, 32'h0);
    chk({tag, ".rdata_hold"}, s_rdata, exp_rdata);
  endtask

  initial begin
    #1;
    chk("rst.s_done", {31'h0, s_done}, 32'h0);
    chk("rst.s_fault", {31'h0, s_fault}, 32'h0);
    chk("rst.mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst.s_rdata", s_rdata, 32'h0);
    chk("rst.mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.fault_cnt", {16'h0, fault_cnt}, 32'h0);
    chk("rst.fault_addr", fault_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd_val = 32'hDEAD_BEEF;
    run_txn("rd200", 1'b0, 4'hF, 32'h2000_0200, 32'h0, 4, 1'b0, 32'hDEAD_BEEF, 10'h080, 1'b0, 1'b0);

    run_txn("wr_ro", 1'b1, 4'hF, 32'h2000_0040, 32'h5555_5555, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    chk("wr_ro.fault_cnt", {16'h0, fault_cnt}, 32'd1);
    chk("wr_ro.fault_addr", fault_addr, 32'h2000_0040);

    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr.fault_cnt", {16'h0, fault_cnt}, 32'd0);

    run_txn("rd_past", 1'b0, 4'hF, 32'h2000_1000, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    run_txn("rd_unal", 1'b0, 4'hF, 32'h2000_0002, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    chk("two_faults.fault_cnt", {16'h0, fault_cnt}, 32'd2);
    chk("two_faults.fault_addr", fault_addr, 32'h2000_0002);

    run_txn("wr_top", 1'b1, 4'h3, 32'h2000_0FFC, 32'h0000_1234, 2, 1'b0, 32'h0, 10'h3FF, 1'b0, 1'b0);
    run_txn("be_zero", 1'b0, 4'h0, 32'h2000_0400, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    run_txn("below", 1'b0, 4'hF, 32'h1FFF_FFFC, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    chk("below.fault_addr", fault_addr, 32'h1FFF_FFFC);
    chk("faults4.fault_cnt", {16'h0, fault_cnt}, 32'd4);

    // read from write-protected region is allowed, and back-to-back with the next write
    rd_val = 32'h1122_3344;
    run_txn("rd_ro", 1'b0, 4'h1, 32'h2000_0010, 32'h0, 4, 1'b0, 32'h1122_3344, 10'h004, 1'b0, 1'b0);
    run_txn("wr_ro_end", 1'b1, 4'hC, 32'h2000_0100, 32'hCAFE_F00D, 2, 1'b0, 32'h0, 10'h040, 1'b0, 1'b0);

    rd_val = 32'h0A0B_0C0D;
    run_txn("rd_drop", 1'b0, 4'hF, 32'h2000_0FFC, 32'h0, 4, 1'b0, 32'h0A0B_0C0D, 10'h3FF, 1'b1, 1'b0);
    chk("nofault.fault_cnt", {16'h0, fault_cnt}, 32'd4);

    force dut.fault_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fault_cnt_q;
    @(negedge clk);
    chk("sat.preset", {16'h0, fault_cnt}, 32'h0000_FFFF);
    run_txn("sat", 1'b1, 4'hF, 32'h2000_00F0, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b0);
    chk("sat.fault_cnt", {16'h0, fault_cnt}, 32'h0000_FFFF);
    run_txn("clr_fault", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1, 1'b1, 32'h0, 10'h0, 1'b0, 1'b1);
    chk("clr_fault.fault_cnt", {16'h0, fault_cnt}, 32'd0);
    chk("clr_fault.fault_addr", fault_addr, 32'h3000_0000);

    // reset while the read sits in WAIT
    rd_val = 32'h7777_8888;
    s_req = 1'b1; s_we = 1'b0; s_be = 4'hF; s_addr = 32'h2000_0300;
    @(negedge clk);
    chk("rstw.mem_en", {31'h0, mem_en}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    s_req = 1'b0;
    #1;
    chk("rstw.s_done", {31'h0, s_done}, 32'h0);
    chk("rstw.mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rstw.mem_be", {28'h0, mem_be}, 32'h0);
    chk("rstw.fault_addr", fault_addr, 32'h0);
    chk("rstw.s_rdata", s_rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("rstw.no_done", {31'h0, s_done}, 32'h0);
      chk("rstw.no_mem_en", {31'h0, mem_en}, 32'h0);
    end
    run_txn("rd_after_rst", 1'b0, 4'hF, 32'h2000_0300, 32'h0, 4, 1'b0, 32'h7777_8888, 10'h0C0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
